instruction_fetch_stage: RTL and testbench

// - IF stage of the 5-stage ARM core: owns the architectural PC register and drives instruction memory.
// - Loads the IF/ID pipeline register.
// - Consumes the branch redirect produced in EX by branchAddressGenerator (PC + (sext(imm24)<<2) + 4).
// - Presents to that generator, via IF/ID, the PC+4 value it expects as its PC operand.

---
 rtl/core_pkg.sv | 20 ++
 rtl/instruction_fetch_stage_if.sv | 26 ++
 rtl/instruction_fetch_stage_pc_register.sv | 42 ++++
 rtl/instruction_fetch_stage.sv | 96 +++++++++
 tb/tb_instruction_fetch_stage.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and constants for the fetch stage
package core_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INCR           = 32'd4;
  localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 32'hE1A0_0000;  // MOV r0,r0
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic {
    FETCH_RUN      = 1'b0,
    FETCH_REDIRECT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// rtl/instruction_fetch_stage_if.sv - instruction memory request/response bundle
interface instruction_fetch_stage_if;
  import core_pkg::*;

  logic [WORD_W-1:0] imem_addr;
  logic              imem_req;
  logic              imem_ready;
  logic [WORD_W-1:0] imem_rdata;

  // Fetch stage side
  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ready,
    input  imem_rdata
  );

  // Instruction memory side
  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/instruction_fetch_stage_pc_register.sv
// rtl/instruction_fetch_stage_pc_register.sv - architectural PC with load/increment/hold
module pc_register
  import core_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] target_i,
  input  logic              incr_i,
  output logic [WORD_W-1:0] pc_o,
  output logic [WORD_W-1:0] pc_plus4_o
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;

  // Sequential successor; wraps modulo 2^32
  assign pc_plus4_o = pc_q + PC_INCR;
  assign pc_o       = pc_q;

  // Next PC: redirect target (forced word-aligned) beats increment beats hold
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i & 32'hFFFF_FFFC;
    end else if (incr_i) begin
      pc_d = pc_plus4_o;
    end
  end

  // PC register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage: PC, imem drive, IF/ID register, redirect FSM
module instruction_fetch_stage
  import core_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      stall_i,
  input  logic                      branch_taken_i,
  input  logic [WORD_W-1:0]         branch_address_i,
  instruction_fetch_stage_if.master imem,
  output logic                      if_id_valid_o,
  output logic [WORD_W-1:0]         if_id_pc_plus4_o,
  output logic [WORD_W-1:0]         if_id_instr_o,
  output logic [15:0]               redirect_count_o,
  output fetch_state_t              fetch_state_o
);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_plus4;
  logic              pc_incr;

  if_id_t       if_id_q, if_id_d;
  logic [15:0]  count_q, count_d;
  fetch_state_t state_q, state_d;

  // A fetch only retires when nothing of higher priority claims the cycle
  assign pc_incr = !branch_taken_i && !stall_i && imem.imem_ready;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (branch_taken_i),
    .target_i   (branch_address_i),
    .incr_i     (pc_incr),
    .pc_o       (pc),
    .pc_plus4_o (pc_plus4)
  );

  assign imem.imem_addr = pc;
  assign imem.imem_req  = !rst_i;

  // IF/ID next value: branch bubble, stall hold, capture on ready, else bubble
  always_comb begin
    if_id_d = if_id_q;
    if (branch_taken_i) begin
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
    end else if (stall_i) begin
      if_id_d = if_id_q;
    end else if (imem.imem_ready) begin
      if_id_d.valid    = 1'b1;
      if_id_d.pc_plus4 = pc_plus4;
      if_id_d.instr    = imem.imem_rdata;
    end else begin
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
    end
  end

  // Redirect counter and FSM: REDIRECT lasts exactly as long as branches keep arriving
  always_comb begin
    count_d = count_q;
    state_d = FETCH_RUN;
    if (branch_taken_i) begin
      count_d = count_q + 16'd1;
      state_d = FETCH_REDIRECT;
    end
  end

  // Pipeline register, counter and FSM state; reset overrides every other effect
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_id_q.valid    <= 1'b0;
      if_id_q.pc_plus4 <= '0;
      if_id_q.instr    <= NOP_INSTR;
      count_q          <= '0;
      state_q          <= FETCH_RUN;
    end else begin
      if_id_q <= if_id_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign if_id_valid_o    = if_id_q.valid;
  assign if_id_pc_plus4_o = if_id_q.pc_plus4;
  assign if_id_instr_o    = if_id_q.instr;
  assign redirect_count_o = count_q;
  assign fetch_state_o    = state_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed self-checking bench for instruction_fetch_stage
module tb_instruction_fetch_stage;
  import core_pkg::*;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst, stall, br;
  logic [31:0] br_addr;
  int          errors = 0;
  int          checks = 0;

  logic         valid, valid2;
  logic [31:0]  pcp4, pcp4_2, instr, instr2;
  logic [15:0]  count, count2;
  fetch_state_t state, state2;

  instruction_fetch_stage_if if0 ();
  instruction_fetch_stage_if if1 ();

  assign if1.imem_ready = if0.imem_ready;
  assign if1.imem_rdata = if0.imem_rdata;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .stall_i          (stall),
    .branch_taken_i   (br),
    .branch_address_i (br_addr),
    .imem             (if0),
    .if_id_valid_o    (valid),
    .if_id_pc_plus4_o (pcp4),
    .if_id_instr_o    (instr),
    .redirect_count_o (count),
    .fetch_state_o    (state)
  );

  instruction_fetch_stage #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk_i            (clk),
    .rst_i            (rst),
    .stall_i          (stall),
    .branch_taken_i   (br),
    .branch_address_i (br_addr),
    .imem             (if1),
    .if_id_valid_o    (valid2),
    .if_id_pc_plus4_o (pcp4_2),
    .if_id_instr_o    (instr2),
    .redirect_count_o (count2),
    .fetch_state_o    (state2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; br = 1'b0; br_addr = '0;
    if0.imem_ready = 1'b0; if0.imem_rdata = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; br = 1'b0; br_addr = 32'h40;
    if0.imem_ready = 1'b1; if0.imem_rdata = 32'h1111_1111;
    tick();
    checks++; if (if0.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", if0.imem_addr, 32'h0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
    checks++; if (pcp4 !== 32'h0) begin errors++; $display("FAIL reset_pcp4 got=%h exp=0", pcp4); end
    checks++; if (count !== 16'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", count); end
    checks++; if (state !== FETCH_RUN) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state, FETCH_RUN); end
    checks++; if (if0.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", if0.imem_req); end
    checks++; if (if1.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_param got=%h exp=FFFFFFFC", if1.imem_addr); end
    rst = 1'b0;
    #1;
    checks++; if (if0.imem_req !== 1'b1) begin errors++; $display("FAIL req_after_reset got=%b exp=1", if0.imem_req); end
  endtask

  task automatic test_fetch();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if0.imem_ready = 1'b1;
      if0.imem_rdata = 32'hA000_0000 + k;
      checks++; if (if0.imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL fetch_addr%0d got=%h exp=%h", k, if0.imem_addr, 32'(4 * k)); end
      tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL fetch_valid%0d got=%b exp=1", k, valid); end
      checks++; if (pcp4 !== 32'(4 * k + 4)) begin errors++; $display("FAIL fetch_pcp4_%0d got=%h exp=%h", k, pcp4, 32'(4 * k + 4)); end
      checks++; if (instr !== 32'hA000_0000 + k) begin errors++; $display("FAIL fetch_instr%0d got=%h exp=%h", k, instr, 32'hA000_0000 + k); end
      if (k == 0) begin
        checks++; if (if1.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=0", if1.imem_addr); end
        checks++; if (pcp4_2 !== 32'h0) begin errors++; $display("FAIL wrap_pcp4 got=%h exp=0", pcp4_2); end
        checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%b exp=1", valid2); end
      end
    end
    checks++; if (if0.imem_addr !== 32'h10) begin errors++; $display("FAIL fetch_addr_end got=%h exp=10", if0.imem_addr); end
  endtask

  task automatic test_branch();
    do_reset();
    if0.imem_ready = 1'b1; if0.imem_rdata = 32'h1234_5678;
    tick(); tick();
    br = 1'b1; br_addr = 32'h40; if0.imem_rdata = 32'h5555_5555;
    tick();
    br = 1'b0; if0.imem_rdata = 32'h7777_0040;
    checks++; if (if0.imem_addr !== 32'h40) begin errors++; $display("FAIL br_addr got=%h exp=40", if0.imem_addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL br_valid got=%b exp=0", valid); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL br_instr got=%h exp=%h", instr, NOP); end
    checks++; if (pcp4 !== 32'h8) begin errors++; $display("FAIL br_pcp4_hold got=%h exp=8", pcp4); end
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL br_count got=%0d exp=1", count); end
    checks++; if (state !== FETCH_REDIRECT) begin errors++; $display("FAIL br_state got=%0d exp=%0d", state, FETCH_REDIRECT); end
    tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL br_next_valid got=%b exp=1", valid); end
    checks++; if (pcp4 !== 32'h44) begin errors++; $display("FAIL br_next_pcp4 got=%h exp=44", pcp4); end
    checks++; if (instr !== 32'h7777_0040) begin errors++; $display("FAIL br_next_instr got=%h exp=77770040", instr); end
    checks++; if (state !== FETCH_RUN) begin errors++; $display("FAIL br_exit_state got=%0d exp=%0d", state, FETCH_RUN); end
  endtask

  task automatic test_stall();
    do_reset();
    if0.imem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if0.imem_rdata = 32'hA000_0000 + k;
      tick();
    end
    stall = 1'b1; if0.imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (if0.imem_addr !== 32'hC) begin errors++; $display("FAIL stall_addr%0d got=%h exp=C", k, if0.imem_addr); end
      checks++; if (pcp4 !== 32'hC) begin errors++; $display("FAIL stall_pcp4_%0d got=%h exp=C", k, pcp4); end
      checks++; if (instr !== 32'hA000_0002) begin errors++; $display("FAIL stall_instr%0d got=%h exp=A0000002", k, instr); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got=%b exp=1", k, valid); end
    end
    stall = 1'b0; if0.imem_rdata = 32'hB000_0003;
    tick();
    checks++; if (if0.imem_addr !== 32'h10) begin errors++; $display("FAIL unstall_addr got=%h exp=10", if0.imem_addr); end
    checks++; if (pcp4 !== 32'h10) begin errors++; $display("FAIL unstall_pcp4 got=%h exp=10", pcp4); end
    checks++; if (instr !== 32'hB000_0003) begin errors++; $display("FAIL unstall_instr got=%h exp=B0000003", instr); end
  endtask

  task automatic test_stall_branch();
    stall = 1'b1; br = 1'b1; br_addr = 32'h103;
    tick();
    stall = 1'b0; br = 1'b0;
    checks++; if (if0.imem_addr !== 32'h100) begin errors++; $display("FAIL sb_addr got=%h exp=100", if0.imem_addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sb_valid got=%b exp=0", valid); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL sb_instr got=%h exp=%h", instr, NOP); end
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL sb_count got=%0d exp=1", count); end
    checks++; if (pcp4 !== 32'h10) begin errors++; $display("FAIL sb_pcp4_hold got=%h exp=10", pcp4); end
    checks++; if (state !== FETCH_REDIRECT) begin errors++; $display("FAIL sb_state got=%0d exp=%0d", state, FETCH_REDIRECT); end
  endtask

  task automatic test_not_ready();
    if0.imem_ready = 1'b0; if0.imem_rdata = 32'hBAD0_BAD0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (if0.imem_addr !== 32'h100) begin errors++; $display("FAIL nr_addr%0d got=%h exp=100", k, if0.imem_addr); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL nr_valid%0d got=%b exp=0", k, valid); end
      checks++; if (instr !== NOP) begin errors++; $display("FAIL nr_instr%0d got=%h exp=%h", k, instr, NOP); end
      checks++; if (state !== FETCH_RUN) begin errors++; $display("FAIL nr_state%0d got=%0d exp=%0d", k, state, FETCH_RUN); end
    end
    if0.imem_ready = 1'b1; if0.imem_rdata = 32'h0000_C0DE;
    tick();
    checks++; if (if0.imem_addr !== 32'h104) begin errors++; $display("FAIL nr_resume_addr got=%h exp=104", if0.imem_addr); end
    checks++; if (pcp4 !== 32'h104) begin errors++; $display("FAIL nr_resume_pcp4 got=%h exp=104", pcp4); end
    checks++; if (instr !== 32'h0000_C0DE) begin errors++; $display("FAIL nr_resume_instr got=%h exp=C0DE", instr); end
  endtask

  task automatic test_reset_in_redirect();
    do_reset();
    if0.imem_ready = 1'b1; if0.imem_rdata = 32'h2222_2222;
    br = 1'b1; br_addr = 32'h80;
    tick();
    checks++; if (state !== FETCH_REDIRECT) begin errors++; $display("FAIL rr_pre_state got=%0d exp=%0d", state, FETCH_REDIRECT); end
    rst = 1'b1;
    tick();
    checks++; if (state !== FETCH_RUN) begin errors++; $display("FAIL rr_state got=%0d exp=%0d", state, FETCH_RUN); end
    checks++; if (if0.imem_addr !== 32'h0) begin errors++; $display("FAIL rr_pc got=%h exp=0", if0.imem_addr); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL rr_count got=%0d exp=0", count); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rr_valid got=%b exp=0", valid); end
    rst = 1'b0; br = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    if0.imem_ready = 1'b1;
    br = 1'b1; br_addr = 32'h0000_0202;
    repeat (65535) tick();
    checks++; if (count !== 16'hFFFF) begin errors++; $display("FAIL b2b_count_max got=%h exp=FFFF", count); end
    checks++; if (state !== FETCH_REDIRECT) begin errors++; $display("FAIL b2b_state got=%0d exp=%0d", state, FETCH_REDIRECT); end
    checks++; if (if0.imem_addr !== 32'h200) begin errors++; $display("FAIL b2b_addr got=%h exp=200", if0.imem_addr); end
    tick();
    checks++; if (count !== 16'h0000) begin errors++; $display("FAIL b2b_count_wrap got=%h exp=0", count); end
    br = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_branch();
    test_stall();
    test_stall_branch();
    test_not_ready();
    test_reset_in_redirect();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
